// File: rtl/pipeline_hazard_controller_pkg.sv
// Shared types and defaults for the pipeline hazard controller.
package pipeline_hazard_controller_pkg;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_e;

  localparam int WAIT_LIMIT_DEF = 255;
  localparam int CNT_W_DEF      = 16;
  localparam int WAIT_W         = 8;

  // Register 0 is not special: a match is a plain compare gated by write-back enable.
  function automatic logic reg_match(input logic [3:0] src, input logic [3:0] dst,
                                     input logic wb_en);
    return wb_en && (src == dst);
  endfunction

endpackage

// File: rtl/pipeline_hazard_controller_if.sv
// Pipeline-side bundle: stage register tags and enables in, stall/flush controls and counters out.
interface pipeline_hazard_controller_if
  import pipeline_hazard_controller_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
);
  logic             forward_en;
  logic [3:0]       Rn_src;
  logic [3:0]       Rm_src;
  logic             Two_src;
  logic [3:0]       EXE_Dest;
  logic [3:0]       MEM_Dest;
  logic             EXE_WB_EN;
  logic             MEM_WB_EN;
  logic             EXE_MEM_R_EN;
  logic             branch_taken;
  logic             mem_req;
  logic             mem_ready;
  logic             hazard_freeze;
  logic             id_bubble;
  logic             if_flush;
  logic             pipe_freeze;
  logic             mem_timeout;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_count;

  modport master (
    output forward_en, Rn_src, Rm_src, Two_src, EXE_Dest, MEM_Dest,
           EXE_WB_EN, MEM_WB_EN, EXE_MEM_R_EN, branch_taken, mem_req, mem_ready,
    input  hazard_freeze, id_bubble, if_flush, pipe_freeze, mem_timeout,
           stall_cycles, flush_count
  );

  modport slave (
    input  forward_en, Rn_src, Rm_src, Two_src, EXE_Dest, MEM_Dest,
           EXE_WB_EN, MEM_WB_EN, EXE_MEM_R_EN, branch_taken, mem_req, mem_ready,
    output hazard_freeze, id_bubble, if_flush, pipe_freeze, mem_timeout,
           stall_cycles, flush_count
  );

endinterface

// File: rtl/pipeline_hazard_controller_sat_counter.sv
// Saturating up-counter with synchronous clear; value visible one cycle after inc.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (clr_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Hazard/flush/freeze control: stall and flush decisions are combinational, memory-wait
// tracking, timeout flag and performance counters are registered.
module pipeline_hazard_controller
  import pipeline_hazard_controller_pkg::*;
#(
  parameter int WAIT_LIMIT = WAIT_LIMIT_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input logic                          clk,
  input logic                          rst,
  pipeline_hazard_controller_if.slave  bus
);

  localparam logic [WAIT_W-1:0] LIMIT = WAIT_W'(WAIT_LIMIT);

  logic rn_exe, rn_mem, rm_exe, rm_mem;
  logic hazard, pipe_freeze, hazard_freeze, if_flush, id_bubble;

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              mem_timeout_q, mem_timeout_d;
  logic [CNT_W-1:0]  stall_cnt, flush_cnt;

  always_comb begin
    rn_exe = reg_match(bus.Rn_src, bus.EXE_Dest, bus.EXE_WB_EN);
    rn_mem = reg_match(bus.Rn_src, bus.MEM_Dest, bus.MEM_WB_EN);
    rm_exe = bus.Two_src && reg_match(bus.Rm_src, bus.EXE_Dest, bus.EXE_WB_EN);
    rm_mem = bus.Two_src && reg_match(bus.Rm_src, bus.MEM_Dest, bus.MEM_WB_EN);
    // With forwarding only a load in EXE cannot be bypassed in time.
    if (bus.forward_en) begin
      hazard = bus.EXE_MEM_R_EN && (rn_exe || rm_exe);
    end else begin
      hazard = rn_exe || rn_mem || rm_exe || rm_mem;
    end
    pipe_freeze   = bus.mem_req && !bus.mem_ready;
    if_flush      = !pipe_freeze && bus.branch_taken;
    hazard_freeze = !pipe_freeze && !bus.branch_taken && hazard;
    id_bubble     = if_flush || hazard_freeze;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:      if (pipe_freeze) state_d = MEM_WAIT;
      MEM_WAIT: if (bus.mem_ready || !bus.mem_req) state_d = RUN;
      default:  state_d = RUN;
    endcase

    wait_cnt_d = wait_cnt_q;
    if (state_d == RUN) begin
      wait_cnt_d = '0;
    end else if ((state_q == MEM_WAIT) && (wait_cnt_q != LIMIT)) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end

    mem_timeout_d = mem_timeout_q || ((state_q == MEM_WAIT) && (wait_cnt_q == LIMIT));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= RUN;
      wait_cnt_q    <= '0;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .clr_i (rst),
    .inc_i (pipe_freeze || hazard_freeze),
    .cnt_o (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .clr_i (rst),
    .inc_i (if_flush),
    .cnt_o (flush_cnt)
  );

  assign bus.hazard_freeze = hazard_freeze;
  assign bus.id_bubble     = id_bubble;
  assign bus.if_flush      = if_flush;
  assign bus.pipe_freeze   = pipe_freeze;
  assign bus.mem_timeout   = mem_timeout_q;
  assign bus.stall_cycles  = stall_cnt;
  assign bus.flush_count   = flush_cnt;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Randomized and directed bench for pipeline_hazard_controller against a cycle-level reference model.
module tb_pipeline_hazard_controller;
  import pipeline_hazard_controller_pkg::*;

  localparam int CW   = 16;
  localparam int WL   = 255;
  localparam int MAXC = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipeline_hazard_controller_if #(.CNT_W(CW)) bus ();

  pipeline_hazard_controller #(.WAIT_LIMIT(WL), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;

  // reference model state
  bit m_wait;
  int m_seen;
  bit m_to;
  int m_stall, m_flush;
  bit e_pf, e_flush, e_hf, e_bub;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_comb();
    logic [3:0] src [2];
    bit         use_src [2];
    bit         haz;
    src[0] = bus.Rn_src;
    src[1] = bus.Rm_src;
    use_src[0] = 1'b1;
    use_src[1] = bus.Two_src;
    haz = 1'b0;
    for (int s = 0; s < 2; s++) begin
      if (use_src[s]) begin
        if (bus.EXE_WB_EN && src[s] == bus.EXE_Dest && (!bus.forward_en || bus.EXE_MEM_R_EN)) haz = 1'b1;
        if (bus.MEM_WB_EN && src[s] == bus.MEM_Dest && !bus.forward_en) haz = 1'b1;
      end
    end
    e_pf    = bus.mem_req && !bus.mem_ready;
    e_flush = !e_pf && bus.branch_taken;
    e_hf    = !e_pf && !bus.branch_taken && haz;
    e_bub   = e_flush || e_hf;
  endtask

  task automatic model_reset();
    m_wait = 0; m_seen = 0; m_to = 0; m_stall = 0; m_flush = 0;
  endtask

  task automatic model_edge();
    if (rst) begin
      model_reset();
    end else begin
      if (m_wait) begin
        m_seen++;
        if (m_seen > WL) m_to = 1;
      end
      if ((e_pf || e_hf) && m_stall < MAXC) m_stall++;
      if (e_flush && m_flush < MAXC) m_flush++;
      m_wait = e_pf;
      if (!m_wait) m_seen = 0;
    end
  endtask

  task automatic check_all();
    model_comb();
    check("pipe_freeze", bus.pipe_freeze, e_pf);
    check("if_flush", bus.if_flush, e_flush);
    check("hazard_freeze", bus.hazard_freeze, e_hf);
    check("id_bubble", bus.id_bubble, e_bub);
    check("mem_timeout", bus.mem_timeout, m_to);
    check("stall_cycles", bus.stall_cycles, m_stall);
    check("flush_count", bus.flush_count, m_flush);
  endtask

  // inputs are already applied; check, clock once, advance model
  task automatic cycle();
    #1;
    check_all();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic set_idle();
    bus.forward_en = 0; bus.Rn_src = 0; bus.Rm_src = 0; bus.Two_src = 0;
    bus.EXE_Dest = 0; bus.MEM_Dest = 0; bus.EXE_WB_EN = 0; bus.MEM_WB_EN = 0;
    bus.EXE_MEM_R_EN = 0; bus.branch_taken = 0; bus.mem_req = 0; bus.mem_ready = 0;
  endtask

  task automatic set_rand();
    bus.forward_en   = 1'($urandom_range(0, 1));
    bus.Rn_src       = 4'($urandom_range(0, 3));
    bus.Rm_src       = 4'($urandom_range(0, 3));
    bus.Two_src      = 1'($urandom_range(0, 1));
    bus.EXE_Dest     = 4'($urandom_range(0, 3));
    bus.MEM_Dest     = 4'($urandom_range(0, 3));
    bus.EXE_WB_EN    = 1'($urandom_range(0, 1));
    bus.MEM_WB_EN    = 1'($urandom_range(0, 1));
    bus.EXE_MEM_R_EN = 1'($urandom_range(0, 1));
    bus.branch_taken = ($urandom_range(0, 7) == 0);
    bus.mem_req      = ($urandom_range(0, 3) == 0);
    bus.mem_ready    = 1'($urandom_range(0, 1));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    set_idle();
    cycle();
    rst = 1'b0;
  endtask

  task automatic set_mem_hazard();
    set_idle();
    bus.Rn_src = 4'd3; bus.MEM_Dest = 4'd3; bus.MEM_WB_EN = 1'b1;
  endtask

  initial begin
    rst = 1'b1;
    set_idle();
    model_reset();
    @(posedge clk);
    #1;
    do_reset();
    check("rst_stall", bus.stall_cycles, 0);
    check("rst_flush", bus.flush_count, 0);
    check("rst_timeout", bus.mem_timeout, 0);

    // non-forwarding MEM-stage dependency
    set_mem_hazard();
    cycle();
    check("h036_hf", bus.hazard_freeze, 1);
    check("h036_bubble", bus.id_bubble, 1);
    check("h036_stall", bus.stall_cycles, 1);

    // load-use with forwarding on the Rm port
    set_idle();
    bus.forward_en = 1; bus.Rm_src = 4'd5; bus.Two_src = 1; bus.EXE_Dest = 4'd5;
    bus.EXE_WB_EN = 1; bus.EXE_MEM_R_EN = 1;
    cycle();
    check("h037_load_hf", bus.hazard_freeze, 1);
    check("h037_load_stall", bus.stall_cycles, 2);
    bus.EXE_MEM_R_EN = 0;
    cycle();
    check("h037_alu_hf", bus.hazard_freeze, 0);
    check("h037_alu_bubble", bus.id_bubble, 0);
    check("h037_alu_stall", bus.stall_cycles, 2);

    // branch beats hazard
    set_mem_hazard();
    bus.branch_taken = 1;
    cycle();
    check("b038_flush", bus.if_flush, 1);
    check("b038_bubble", bus.id_bubble, 1);
    check("b038_hf", bus.hazard_freeze, 0);
    check("b038_flush_cnt", bus.flush_count, 1);

    // long memory wait with a hazard present underneath
    do_reset();
    set_mem_hazard();
    bus.branch_taken = 1;
    bus.mem_req = 1; bus.mem_ready = 0;
    for (int i = 1; i <= 300; i++) begin
      cycle();
      check("w039_pf", bus.pipe_freeze, 1);
      check("w039_masked", {bus.hazard_freeze, bus.if_flush, bus.id_bubble}, 0);
      if (i == 256) check("w039_to_early", bus.mem_timeout, 0);
      if (i == 257) check("w039_to_rise", bus.mem_timeout, 1);
    end
    check("w039_stall", bus.stall_cycles, 300);
    check("w039_flush_cnt", bus.flush_count, 0);

    // reset in the middle of a wait
    set_idle();
    cycle();
    bus.mem_req = 1; bus.mem_ready = 0;
    repeat (10) cycle();
    rst = 1'b1;
    cycle();
    check("r040_pf_in_rst", bus.pipe_freeze, 1);
    check("r040_state", dut.state_q, RUN);
    check("r040_stall", bus.stall_cycles, 0);
    check("r040_flush", bus.flush_count, 0);
    check("r040_timeout", bus.mem_timeout, 0);
    rst = 1'b0;
    repeat (5) cycle();

    // saturation of the stall counter
    do_reset();
    bus.mem_req = 1; bus.mem_ready = 0;
    repeat (65540) cycle();
    check("s041_stall_sat", bus.stall_cycles, 65535);
    check("s041_timeout", bus.mem_timeout, 1);

    // random traffic against the model
    do_reset();
    repeat (4000) begin
      set_rand();
      cycle();
    end
    set_idle();
    cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
